sevenseg_rx_decoder: RTL and testbench

- Receive-side counterpart of the hex-to-seven-segment driver.
- Samples a 7-bit active-high segment bus (bit 6 = seg a … bit 0 = seg g), filters transitions, and decodes each stable pattern back to a 4-bit hex digit.
- Tracks whether the recovered digits form a +1 mod 16 sequence, as produced by the free-running 4-bit display counter.
- Used as an on-chip loopback checker for the counter/display path.

---
 rtl/sevenseg_pkg.sv | 76 +++++++
 rtl/sevenseg_stable_filter.sv | 44 ++++
 rtl/sevenseg_rx_decoder.sv | 95 +++++++++
 tb/tb_sevenseg_rx_decoder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared seven-segment glyph constants, glyph<->digit helpers and the
// loopback-checker lock state type; segment order is {a,b,c,d,e,f,g}.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h1F;
  localparam logic [6:0] SEG_C = 7'h4E;
  localparam logic [6:0] SEG_D = 7'h3D;
  localparam logic [6:0] SEG_E = 7'h4F;
  localparam logic [6:0] SEG_F = 7'h47;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  // Returns {legal, digit}; unknown glyphs return legal=0, digit=0.
  function automatic logic [4:0] seg_to_digit(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      SEG_0:   r = 5'h10;
      SEG_1:   r = 5'h11;
      SEG_2:   r = 5'h12;
      SEG_3:   r = 5'h13;
      SEG_4:   r = 5'h14;
      SEG_5:   r = 5'h15;
      SEG_6:   r = 5'h16;
      SEG_7:   r = 5'h17;
      SEG_8:   r = 5'h18;
      SEG_9:   r = 5'h19;
      SEG_A:   r = 5'h1A;
      SEG_B:   r = 5'h1B;
      SEG_C:   r = 5'h1C;
      SEG_D:   r = 5'h1D;
      SEG_E:   r = 5'h1E;
      SEG_F:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Transmit-side view used by the hex-to-segment driver.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'h0: r = SEG_0;
      4'h1: r = SEG_1;
      4'h2: r = SEG_2;
      4'h3: r = SEG_3;
      4'h4: r = SEG_4;
      4'h5: r = SEG_5;
      4'h6: r = SEG_6;
      4'h7: r = SEG_7;
      4'h8: r = SEG_8;
      4'h9: r = SEG_9;
      4'hA: r = SEG_A;
      4'hB: r = SEG_B;
      4'hC: r = SEG_C;
      4'hD: r = SEG_D;
      4'hE: r = SEG_E;
      default: r = SEG_F;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sevenseg_stable_filter.sv
// Two-flop synchronizer, stability counter and last-accepted-pattern compare;
// emits a one-cycle accept strobe with the stable pattern.
module sevenseg_stable_filter #(
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  output logic       accept,
  output logic [6:0] pattern
);
  import sevenseg_pkg::*;

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);

  logic [6:0] s1;
  logic [6:0] s2;
  logic [6:0] last;
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      last <= '0;
      cnt  <= '0;
    end else begin
      s1 <= seg_in;
      s2 <= s1;
      // s1 != s2 means s2 changes on this edge, so the new value starts at 1
      if (s1 != s2)
        cnt <= 4'd1;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 4'd1;
      if (accept)
        last <= s2;
    end
  end

  // Once accepted, s2 equals last, so a held pattern cannot re-fire.
  assign accept  = (cnt == CNT_MAX) && (s2 != last);
  assign pattern = s2;

endmodule

// File: rtl/sevenseg_rx_decoder.sv
// Seven-segment receive decoder / loopback checker.
// Define SEVENSEG_SEQ_CHECK_EN to enable the +1 mod 16 sequence check FSM.
module sevenseg_rx_decoder #(
  parameter int unsigned STABLE_CYCLES = 3,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       seg_in,
  output logic [3:0]       digit_out,
  output logic             digit_valid,
  output logic             pattern_err,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);
  import sevenseg_pkg::*;

  logic       accept;
  logic [6:0] pattern;
  logic [4:0] lookup;
  logic       legal;
  logic [3:0] digit;
  logic       seq_err_next;
  logic       err_event;

  sevenseg_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .seg_in (seg_in),
    .accept (accept),
    .pattern(pattern)
  );

  assign lookup = seg_to_digit(pattern);
  assign legal  = lookup[4];
  assign digit  = lookup[3:0];

`ifdef SEVENSEG_SEQ_CHECK_EN
  state_t state;
  state_t state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= UNLOCKED;
      seq_err <= 1'b0;
    end else begin
      state   <= state_next;
      seq_err <= seq_err_next;
    end
  end

  // digit_out still holds the previous accepted digit when this evaluates.
  always_comb begin
    state_next   = state;
    seq_err_next = 1'b0;
    if (accept) begin
      if (legal) begin
        if ((state == LOCKED) && (digit != digit_out + 4'd1))
          seq_err_next = 1'b1;
        state_next = LOCKED;
      end else begin
        state_next = UNLOCKED;
      end
    end
  end

  assign locked = (state == LOCKED);
`else
  assign seq_err_next = 1'b0;
  assign seq_err      = 1'b0;
  assign locked       = 1'b0;
`endif

  assign err_event = accept && (!legal || seq_err_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_out   <= '0;
      digit_valid <= 1'b0;
      pattern_err <= 1'b0;
      err_count   <= '0;
    end else begin
      digit_valid <= accept && legal;
      pattern_err <= accept && !legal;
      if (accept && legal)
        digit_out <= digit;
      if (err_event && (err_count != '1))
        err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_sevenseg_rx_decoder.sv
// Self-checking bench for sevenseg_rx_decoder: directed scenarios plus random
// segment streams against a sample-history reference model.
module tb_sevenseg_rx_decoder;

  localparam int N = 3;
`ifdef SEVENSEG_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_in;
  logic [3:0] digit_out, digit_out2;
  logic       digit_valid, pattern_err, seq_err, locked;
  logic       digit_valid2, pattern_err2, seq_err2, locked2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  always #5 clk = ~clk;

  sevenseg_rx_decoder #(.STABLE_CYCLES(N), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .digit_out(digit_out),
    .digit_valid(digit_valid), .pattern_err(pattern_err), .seq_err(seq_err),
    .locked(locked), .err_count(err_count)
  );

  sevenseg_rx_decoder #(.STABLE_CYCLES(N), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .digit_out(digit_out2),
    .digit_valid(digit_valid2), .pattern_err(pattern_err2), .seq_err(seq_err2),
    .locked(locked2), .err_count(err_count2)
  );

  logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [6:0] xs[$];
  logic [6:0] m_last;
  int         m_digit;
  bit         m_locked, m_dv, m_pe, m_se;
  int         m_err, m_err2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int glyph_index(input logic [6:0] p);
    for (int i = 0; i < 16; i++)
      if (glyph[i] == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    xs.delete();
    m_last = 7'h00; m_digit = 0; m_locked = 0;
    m_dv = 0; m_pe = 0; m_se = 0; m_err = 0; m_err2 = 0;
  endtask

  // A pattern is accepted once its synchronized copy has been identical for
  // N samples ending two edges before the output edge, and differs from the
  // last accepted pattern.
  task automatic model_edge(input logic [6:0] p);
    bit stable;
    int d;
    m_dv = 0; m_pe = 0; m_se = 0;
    xs.push_back(p);
    if (xs.size() > N + 2) void'(xs.pop_front());
    if (xs.size() == N + 2) begin
      stable = 1;
      for (int k = 1; k < N; k++)
        if (xs[k] != xs[0]) stable = 0;
      if (stable && xs[0] != m_last) begin
        d = glyph_index(xs[0]);
        m_last = xs[0];
        if (d >= 0) begin
          m_dv = 1;
          if (SEQ_EN && m_locked && d != (m_digit + 1) % 16) m_se = 1;
          m_digit = d;
          m_locked = SEQ_EN;
        end else begin
          m_pe = 1;
          m_locked = 0;
        end
        if (m_pe || m_se) begin
          if (m_err < 255) m_err++;
          if (m_err2 < 3) m_err2++;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("digit_valid", 32'(digit_valid), 32'(m_dv));
    chk("pattern_err", 32'(pattern_err), 32'(m_pe));
    chk("seq_err", 32'(seq_err), 32'(m_se));
    chk("digit_out", 32'(digit_out), 32'(m_digit));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("err_count", 32'(err_count), 32'(m_err));
    chk("err_count_w2", 32'(err_count2), 32'(m_err2));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_digit"}, 32'(digit_out), 0);
    chk({tag, "_dv"}, 32'(digit_valid), 0);
    chk({tag, "_pe"}, 32'(pattern_err), 0);
    chk({tag, "_se"}, 32'(seq_err), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_err"}, 32'(err_count), 0);
    chk({tag, "_err2"}, 32'(err_count2), 0);
  endtask

  task automatic step(input logic [6:0] p);
    seg_in = p;
    @(posedge clk);
    model_edge(p);
    #1;
    compare_all();
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    for (int i = 0; i < n; i++) step(p);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_zero(tag);
    @(posedge clk);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  int first_dv, dv_cnt, se_cnt;
  logic [6:0] rp;

  initial begin
    rst_n  = 1'b0;
    seg_in = 7'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // Single glyph held: one acceptance at edge N+2.
    first_dv = 0;
    for (int i = 0; i < 10; i++) begin
      step(7'h7E);
      if (digit_valid && first_dv == 0) first_dv = i + 1;
    end
    chk("first_latency", 32'(first_dv), 32'(N + 2));

    // Full counting sweep including F->0 wrap.
    do_reset("reset_pre_sweep");
    dv_cnt = 0; se_cnt = 0;
    for (int d = 0; d < 17; d++)
      for (int i = 0; i < 6; i++) begin
        step(glyph[d % 16]);
        if (digit_valid) dv_cnt++;
        if (seq_err) se_cnt++;
      end
    chk("sweep_dv_count", 32'(dv_cnt), 17);
    chk("sweep_seq_err_count", 32'(se_cnt), 0);

    // Sequence break 2 -> 4, then 5 continues cleanly.
    hold(7'h30, 6);
    hold(7'h6D, 6);
    hold(7'h33, 6);
    chk("skip_err_count", 32'(err_count), SEQ_EN ? 1 : 0);
    hold(7'h5B, 6);

    // Glitch rejection, illegal pattern, recovery.
    hold(7'h5F, 6);
    hold(7'h70, 6);
    hold(7'h00, 2);
    hold(7'h70, 6);
    hold(7'h00, 5);
    chk("illegal_holds_digit", 32'(digit_out), 7);
    hold(7'h7F, 6);
    chk("recover_digit", 32'(digit_out), 8);

    // Saturation of the 2-bit error counter.
    for (int k = 0; k < 5; k++) hold((k % 2 == 0) ? 7'h01 : 7'h02, 5);
    chk("err_w2_saturated", 32'(err_count2), 3);

    // Randomized glyph / garbage stream with short and long holds.
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(9) < 7) rp = glyph[$urandom_range(15)];
      else rp = 7'($urandom_range(127));
      hold(rp, int'($urandom_range(6, 1)));
    end

    // Asynchronous reset mid-stream while '1' is displayed.
    hold(7'h30, 6);
    do_reset("reset_mid");
    first_dv = 0;
    se_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(7'h30);
      if (digit_valid && first_dv == 0) first_dv = i + 1;
      if (seq_err) se_cnt++;
    end
    chk("post_reset_latency", 32'(first_dv), 32'(N + 2));
    chk("post_reset_digit", 32'(digit_out), 1);
    chk("post_reset_locked", 32'(locked), 32'(SEQ_EN));
    chk("post_reset_seq_err", 32'(se_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
